// File: rtl/rv32i_alu_unit.sv
// rtl/rv32i_alu_unit.sv - multicycle RV32I ALU behind the controller's alu_en/alu_valid handshake
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the serial one.
module rv32i_alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_en,
   input  logic [4:0]       alu_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] alu_result,
   output logic             alu_valid,
   output logic             alu_busy,
   output logic             illegal_op
);

   localparam logic [4:0] OP_ADD   = 5'b00001;
   localparam logic [4:0] OP_SUB   = 5'b00011;
   localparam logic [4:0] OP_SLT   = 5'b00101;
   localparam logic [4:0] OP_SLTU  = 5'b00110;
   localparam logic [4:0] OP_AND   = 5'b01010;
   localparam logic [4:0] OP_OR    = 5'b01100;
   localparam logic [4:0] OP_XOR   = 5'b01101;
   localparam logic [4:0] OP_SLL   = 5'b01110;
   localparam logic [4:0] OP_SRL   = 5'b01111;
   localparam logic [4:0] OP_SRA   = 5'b10000;
   localparam logic [4:0] OP_LUI   = 5'b10010;
   localparam logic [4:0] OP_AUIPC = 5'b10011;
   localparam logic [4:0] OP_JAL   = 5'b10100;
   localparam logic [4:0] OP_ADDR  = 5'b11000;

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
`endif

   state_t           state;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] exec_result;
   logic             exec_illegal;

`ifdef ALU_FAST_SHIFT_EN
   logic [4:0] shamt;
   assign shamt = b_q[4:0];
`else
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] shift_next;
   logic [4:0]       cnt;
   logic             req_shift;

   assign req_shift = ((alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA))
                      && (op_b[4:0] != 5'd0);

   always_comb begin
      shift_next = {1'b0, work[WIDTH-1:1]};
      case (op_q)
         OP_SLL:  shift_next = {work[WIDTH-2:0], 1'b0};
         OP_SRA:  shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
         default: shift_next = {1'b0, work[WIDTH-1:1]};
      endcase
   end
`endif

   always_comb begin
      exec_result  = '0;
      exec_illegal = 1'b0;
      case (op_q)
         OP_ADD, OP_AUIPC, OP_ADDR: exec_result = a_q + b_q;
         OP_SUB:   exec_result = a_q - b_q;
         OP_SLT:   exec_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_SLTU:  exec_result = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         OP_AND:   exec_result = a_q & b_q;
         OP_OR:    exec_result = a_q | b_q;
         OP_XOR:   exec_result = a_q ^ b_q;
         OP_LUI:   exec_result = b_q;
         OP_JAL:   exec_result = a_q + WIDTH'(4);
`ifdef ALU_FAST_SHIFT_EN
         OP_SLL:   exec_result = a_q << shamt;
         OP_SRL:   exec_result = a_q >> shamt;
         OP_SRA:   exec_result = WIDTH'($signed(a_q) >>> shamt);
`else
         // Only a zero shift amount reaches EXEC in the serial build.
         OP_SLL, OP_SRL, OP_SRA: exec_result = a_q;
`endif
         default:  exec_illegal = 1'b1;
      endcase
   end

   assign alu_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         alu_result <= '0;
         alu_valid  <= 1'b0;
         illegal_op <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
         work       <= '0;
         cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (alu_en) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  op_q  <= alu_op;
                  state <= EXEC;
`ifndef ALU_FAST_SHIFT_EN
                  if (req_shift) begin
                     work  <= op_a;
                     cnt   <= op_b[4:0];
                     state <= SHIFT;
                  end
`endif
               end
            end
            EXEC: begin
               alu_result <= exec_result;
               illegal_op <= exec_illegal;
               alu_valid  <= 1'b1;
               state      <= DONE;
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
               work <= shift_next;
               cnt  <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  alu_result <= shift_next;
                  alu_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
`endif
            DONE: begin
               // alu_en is still high in the valid cycle; wait for it to drop.
               alu_valid  <= 1'b0;
               illegal_op <= 1'b0;
               if (!alu_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_alu_unit.sv
// tb/tb_rv32i_alu_unit.sv - self-checking bench for rv32i_alu_unit against a transaction-level model
module tb_rv32i_alu_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_en = 1'b0;
   logic [4:0]  alu_op = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] alu_result;
   logic        alu_valid;
   logic        alu_busy;
   logic        illegal_op;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   rv32i_alu_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .alu_en(alu_en), .alu_op(alu_op),
      .op_a(op_a), .op_b(op_b), .alu_result(alu_result),
      .alu_valid(alu_valid), .alu_busy(alu_busy), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ill);
      int sh;
      sh  = int'(b[4:0]);
      ill = 1'b0;
      case (op)
         5'b00001, 5'b10011, 5'b11000: res = a + b;
         5'b00011: res = a - b;
         5'b00101: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'b00110: res = (a < b) ? 32'd1 : 32'd0;
         5'b01010: res = a & b;
         5'b01100: res = a | b;
         5'b01101: res = a ^ b;
         5'b01110: res = a << sh;
         5'b01111: res = a >> sh;
         5'b10000: res = 32'($signed(a) >>> sh);
         5'b10010: res = b;
         5'b10100: res = a + 32'd4;
         default: begin res = 32'd0; ill = 1'b1; end
      endcase
   endfunction

   function automatic int ref_latency(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
      return 1;
`else
      if ((op == 5'b01110 || op == 5'b01111 || op == 5'b10000) && b[4:0] != 5'd0)
         return int'(b[4:0]);
      return 1;
`endif
   endfunction

   // Transaction-level model: accept, count down the latency, pulse, then wait for alu_en low.
   int          m_phase = 0;
   int          m_cnt = 0;
   logic        m_valid = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_ill = 1'b0;
   logic [31:0] m_result = '0;
   logic [31:0] p_res;
   logic        p_ill;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_valid = 1'b0; m_busy = 1'b0; m_ill = 1'b0; m_result = '0;
      end else begin
         m_valid = 1'b0;
         m_ill   = 1'b0;
         case (m_phase)
            0: if (alu_en) begin
                  ref_op(alu_op, op_a, op_b, p_res, p_ill);
                  m_cnt   = ref_latency(alu_op, op_b);
                  m_phase = 1;
                  m_busy  = 1'b1;
               end
            1: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     m_valid  = 1'b1;
                     m_ill    = p_ill;
                     m_result = p_res;
                     m_phase  = 2;
                  end
               end
            default: if (!alu_en) begin
                  m_phase = 0;
                  m_busy  = 1'b0;
               end
         endcase
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", {31'd0, alu_valid}, {31'd0, m_valid});
         check("busy", {31'd0, alu_busy}, {31'd0, m_busy});
         check("illegal", {31'd0, illegal_op}, {31'd0, m_ill});
         check("result", alu_result, m_result);
      end
   end

   // Issue one request; lat < 0 skips the latency literal, chk = 0 skips the result literal.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit chk, input logic [31:0] lit,
                        input bit lit_ill, input int lat);
      int n;
      bit got;
      @(posedge clk); #2;
      alu_en = 1'b1; alu_op = op; op_a = a; op_b = b;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk);
         n++;
         if (!hold && n == 1) begin #2; alu_en = 1'b0; end
         @(negedge clk);
         if (alu_valid) got = 1'b1;
      end
      if (!got) begin
         errors++; checks++;
         $display("FAIL timeout op=%05b: no alu_valid within 40 edges", op);
      end else begin
         if (lat >= 0) check("latency", 32'(n - 1), 32'(lat));
         if (chk) begin
            check("lit_result", alu_result, lit);
            check("lit_illegal", {31'd0, illegal_op}, {31'd0, lit_ill});
         end
      end
      if (hold) begin
         @(posedge clk); @(negedge clk);
         check("no_repulse", {31'd0, alu_valid}, 32'd0);
      end
      @(posedge clk); #2;
      alu_en = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      logic [4:0] ops [14];
      ops = '{5'b00001, 5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100, 5'b01101,
              5'b01110, 5'b01111, 5'b10000, 5'b10010, 5'b10011, 5'b10100, 5'b11000};

      repeat (2) @(posedge clk);
      #2; rst = 1'b0;
      @(negedge clk);
      check("rst_result", alu_result, 32'd0);
      check("rst_busy", {31'd0, alu_busy}, 32'd0);

      do_op(5'b00001, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1);
      do_op(5'b00101, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd1, 1'b0, 1);
      do_op(5'b00110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd0, 1'b0, 1);
      do_op(5'b00011, 32'd0, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);
`ifdef ALU_FAST_SHIFT_EN
      do_op(5'b10000, 32'h8000_0000, 32'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);
`else
      do_op(5'b10000, 32'h8000_0000, 32'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 31);
`endif
      do_op(5'b01110, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);
      do_op(5'b11111, 32'd5, 32'd6, 1'b1, 1'b1, 32'd0, 1'b1, 1);
      do_op(5'b10010, 32'd0, 32'h1234_5000, 1'b1, 1'b1, 32'h1234_5000, 1'b0, 1);
      do_op(5'b10100, 32'h100, 32'd0, 1'b1, 1'b1, 32'h104, 1'b0, 1);
      do_op(5'b11000, 32'h10, 32'h4, 1'b0, 1'b1, 32'h14, 1'b0, 1);

      // Reset during a long serial shift.
      @(posedge clk); #2;
      alu_en = 1'b1; alu_op = 5'b01111; op_a = 32'hF0F0_F0F0; op_b = 32'd20;
      repeat (5) @(posedge clk);
      #2; rst = 1'b1; alu_en = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midrst_result", alu_result, 32'd0);
      check("midrst_busy", {31'd0, alu_busy}, 32'd0);
      check("midrst_valid", {31'd0, alu_valid}, 32'd0);
      #2; rst = 1'b0;
      do_op(5'b00001, 32'd2, 32'd3, 1'b1, 1'b1, 32'd5, 1'b0, 1);

      for (int i = 0; i < 200; i++) begin
         logic [4:0] op;
         if ($urandom_range(0, 7) == 0) op = 5'($urandom);
         else op = ops[$urandom_range(0, 13)];
         do_op(op, $urandom, $urandom, 1'($urandom), 1'b0, 32'd0, 1'b0,
               ref_latency(op, op_b) > 0 ? -1 : -1);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_alu_unit.md
# rv32i_alu_unit

Multicycle integer ALU for the RV32I core: the responder side of the controller's `alu_en`/`alu_valid` EX-stage handshake. It latches operands and a 5-bit `alu_op` when `alu_en` is sampled high, computes the result, and returns it with a one-cycle `alu_valid` pulse. Shifts execute serially, one bit per cycle, unless the fast-shift option is compiled in. The block sits between the operand muxes (port A/B select) and the write-back mux.

## Interface
- `WIDTH`, 32: datapath width; shift amount is `op_b[4:0]`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_en`  in  1  request; held high by the controller until it sees `alu_valid`.
- `alu_op`  in  5  operation code, sampled with `alu_en`.
- `op_a`  in  WIDTH  operand A, sampled with `alu_en`.
- `op_b`  in  WIDTH  operand B, sampled with `alu_en`.
- `alu_result`  out  WIDTH  registered result; held until the next accepted request.
- `alu_valid`  out  1  single-cycle pulse, result valid.
- `alu_busy`  out  1  high whenever state ≠ IDLE.
- `illegal_op`  out  1  pulses with `alu_valid` when `alu_op` is unknown.

## Operation
- Op codes:
  - 00001 ADD: a+b
  - 00011 SUB: a−b
  - 00101 SLT: signed a<b → 1/0
  - 00110 SLTU: unsigned a<b
  - 01010 AND
  - 01100 OR
  - 01101 XOR
  - 01110 SLL
  - 01111 SRL
  - 10000 SRA
  - 10010 LUI: result=b
  - 10011 AUIPC: a+b
  - 10100 JAL link: a+4
  - 11000 ADDR: a+b
  - Any other code: result 0, `illegal_op`=1.
- Arithmetic is modulo 2^WIDTH; no overflow or carry outputs. SLT/SLTU results are zero-extended to WIDTH.
- States:
  - IDLE: on `alu_en`=1, latch `op_a`, `op_b`, and `alu_op`. A shift with shamt≠0 goes to SHIFT with cnt=shamt; everything else (including shamt=0) goes to EXEC.
  - EXEC: register the result, set `alu_valid`=1, go to DONE.
  - SHIFT: shift the working register by 1 each cycle. SRA replicates the MSB; SRL and SLL fill with 0. Decrement cnt. On the edge where cnt=1, perform the final shift, load `alu_result`, set `alu_valid`=1, and go to DONE.
  - DONE: clear `alu_valid` on the next edge. Stay in DONE while `alu_en`=1; go to IDLE on the first edge with `alu_en`=0. This prevents re-triggering, because the controller's `alu_en` is still high in the `alu_valid` cycle.
- Once accepted, an operation always completes. Deasserting `alu_en` mid-operation does not abort it.
- Inputs are ignored outside IDLE.

## Timing
- Reset (any state, mid-shift included): state=IDLE, `alu_result`=0, `alu_valid`=0, `alu_busy`=0, `illegal_op`=0, cnt=0.
- Let E0 be the edge that samples `alu_en`=1 in IDLE.
  - Non-shift ops and shamt=0: `alu_valid` is high after E1 (latency 1 edge).
  - Shift with shamt=n: `alu_valid` is high after En (latency n edges, max 31).
- `alu_valid` is high for exactly one cycle. `alu_result` is stable from that cycle until the next acceptance.
- Back-to-back: the earliest new acceptance is the edge after `alu_en` is seen low in DONE.
- `alu_busy` rises after E0 and falls on the edge DONE→IDLE.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a barrel shifter and always take the EXEC path (latency 1).
  - The SHIFT state and cnt are not synthesized.
- `ALU_FAST_SHIFT_EN` undefined: serial shifter as described in Operation (latency max(1, shamt)).
- All other ops are identical in both builds.

## Test plan
- ADD: a=0x7FFF_FFFF, b=1, `alu_en` held high → `alu_result`=0x8000_0000, `alu_valid` pulse 1 edge after E0, no second pulse while `alu_en` stays high.
- SLT vs SLTU: a=0xFFFF_FFFF, b=1 → SLT=1, SLTU=0. SUB with a=0, b=1 → 0xFFFF_FFFF.
- SRA: a=0x8000_0000, b=31 → 0xFFFF_FFFF.
  - Serial build: valid 31 edges after E0, `alu_busy` high throughout.
  - Fast build: valid after 1 edge.
  - SLL with b=0 → result=a after 1 edge.
- `rst` asserted on the 5th cycle of SRL with b=20 → IDLE, `alu_result`=0, no `alu_valid` pulse. A following ADD 2+3 → 5.
- Undefined op 11111 → `alu_result`=0, `illegal_op` and `alu_valid` pulse together.
- LUI b=0x1234_5000 → 0x1234_5000. JAL a=0x100 → 0x104. `alu_en` dropped after E0 on ADDR 0x10+0x4 → still completes with 0x14.
